// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
  localparam int INSTR_W  = 32;
  localparam int WSEL_BIT = 2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request-response channels plus the memory-macro bus of the arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic               if_req_valid;
  logic [ADDR_W-1:0]  if_req_addr;
  logic               if_req_ready;
  logic               if_rsp_valid;
  logic [INSTR_W-1:0] if_rsp_data;
  logic               dm_req_valid;
  logic               dm_req_we;
  logic [ADDR_W-1:0]  dm_req_addr;
  logic [DATA_W-1:0]  dm_req_wdata;
  logic               dm_req_ready;
  logic               dm_rsp_valid;
  logic [DATA_W-1:0]  dm_rsp_data;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               busy;

  modport slave (
    input  if_req_valid, if_req_addr, dm_req_valid, dm_req_we, dm_req_addr,
           dm_req_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid,
           dm_rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req_valid, if_req_addr, dm_req_valid, dm_req_we, dm_req_addr,
           dm_req_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid,
           dm_rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant select between fetch and data; data wins unless ARB_STARVE_GUARD_EN
// is defined, which adds a counter that forces a fetch grant after STARVE_MAX data wins.
module mem_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_valid,
  input  logic dm_valid,
  output logic if_ready,
  output logic dm_ready
);
`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_q, starve_d;
  logic            force_if;

  always_comb begin
    force_if = (starve_q == SC_W'(STARVE_MAX)) && if_valid && dm_valid;
    dm_ready = idle && dm_valid && !force_if;
    if_ready = idle && if_valid && !dm_ready;
    starve_d = starve_q;
    // Saturates at STARVE_MAX: reaching it with both valid forces the fetch grant.
    if (if_ready)                  starve_d = '0;
    else if (dm_ready && if_valid) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    dm_ready = idle && dm_valid;
    if_ready = idle && if_valid && !dm_valid;
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store: fixed-latency
// IDLE->ISSUE->WAIT(MEM_LAT)->RESP sequencing with responses routed to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  state_e             state_q, state_d;
  owner_e             own_q, own_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [INSTR_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0]  dm_data_q, dm_data_d;
  logic               if_ready, dm_ready, issue;

  mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk      (clk),
    .reset    (reset),
    .idle     ((state_q == ST_IDLE) && !reset),
    .if_valid (bus.if_req_valid),
    .dm_valid (bus.dm_req_valid),
    .if_ready (if_ready),
    .dm_ready (dm_ready)
  );

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_ready) begin
          state_d = ST_ISSUE;
          own_d   = OWN_DM;
          addr_d  = bus.dm_req_addr;
          we_d    = bus.dm_req_we;
          wdata_d = bus.dm_req_wdata;
        end else if (if_ready) begin
          state_d = ST_ISSUE;
          own_d   = OWN_IF;
          addr_d  = bus.if_req_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          // Capture into the owner's register so the other side's data keeps holding.
          if (own_q == OWN_IF)
            if_data_d = addr_q[WSEL_BIT] ? bus.mem_rdata[2*INSTR_W-1 -: INSTR_W]
                                         : bus.mem_rdata[INSTR_W-1:0];
          else
            dm_data_d = we_q ? '0 : bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      own_q     <= OWN_IF;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  assign issue            = (state_q == ST_ISSUE);
  assign bus.if_req_ready = if_ready;
  assign bus.dm_req_ready = dm_ready;
  assign bus.mem_en       = issue;
  assign bus.mem_we       = issue && we_q;
  assign bus.mem_addr     = issue ? addr_q  : '0;
  assign bus.mem_wdata    = issue ? wdata_q : '0;
  assign bus.if_rsp_valid = (state_q == ST_RESP) && (own_q == OWN_IF);
  assign bus.dm_rsp_valid = (state_q == ST_RESP) && (own_q == OWN_DM);
  assign bus.if_rsp_data  = if_data_q;
  assign bus.dm_rsp_data  = dm_data_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: MEM_LAT=2 arbiter with a small memory model, plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_b ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Memory model for dut_a: writes and read-address latch on the mem_en edge.
  logic [63:0] mem [0:255];
  logic [7:0]  rd_idx = 8'd0;
  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_we) mem[bus_a.mem_addr[10:3]] <= bus_a.mem_wdata;
      rd_idx <= bus_a.mem_addr[10:3];
    end
  end
  assign bus_a.mem_rdata = mem[rd_idx];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] exp_data);
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = addr; #1;
    chk("fetch_if_ready", bus_a.if_req_ready, 1);
    chk("fetch_dm_ready", bus_a.dm_req_ready, 0);
    cyc(1); bus_a.if_req_valid = 1'b0;
    chk("fetch_mem_en", bus_a.mem_en, 1);
    chk("fetch_mem_we", bus_a.mem_we, 0);
    chk("fetch_mem_addr", bus_a.mem_addr, addr);
    chk("fetch_busy", bus_a.busy, 1);
    cyc(2);
    chk("fetch_rsp_early", bus_a.if_rsp_valid, 0);
    cyc(1);
    chk("fetch_rsp_valid", bus_a.if_rsp_valid, 1);
    chk("fetch_rsp_data", bus_a.if_rsp_data, exp_data);
    chk("fetch_dm_rsp", bus_a.dm_rsp_valid, 0);
    cyc(1);
    chk("fetch_idle", bus_a.busy, 0);
    chk("fetch_rsp_pulse", bus_a.if_rsp_valid, 0);
  endtask

  task automatic do_dm(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rsp);
    bus_a.dm_req_valid = 1'b1; bus_a.dm_req_we = we;
    bus_a.dm_req_addr = addr; bus_a.dm_req_wdata = wdata; #1;
    chk("dm_ready", bus_a.dm_req_ready, 1);
    cyc(1); bus_a.dm_req_valid = 1'b0;
    chk("dm_mem_en", bus_a.mem_en, 1);
    chk("dm_mem_we", bus_a.mem_we, we);
    chk("dm_mem_addr", bus_a.mem_addr, addr);
    if (we) chk("dm_mem_wdata", bus_a.mem_wdata, wdata);
    cyc(3);
    chk("dm_rsp_valid", bus_a.dm_rsp_valid, 1);
    chk("dm_rsp_data", bus_a.dm_rsp_data, exp_rsp);
    chk("dm_if_rsp", bus_a.if_rsp_valid, 0);
    cyc(1);
    chk("dm_idle", bus_a.busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    mem[1] = 64'hDEADBEEF_00A00093;
    reset = 1'b1;
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = 64'h8;
    bus_a.dm_req_valid = 1'b1; bus_a.dm_req_we = 1'b0;
    bus_a.dm_req_addr = 64'h0; bus_a.dm_req_wdata = 64'h0;
    bus_b.if_req_valid = 1'b0; bus_b.if_req_addr = 64'h0;
    bus_b.dm_req_valid = 1'b0; bus_b.dm_req_we = 1'b0;
    bus_b.dm_req_addr = 64'h0; bus_b.dm_req_wdata = 64'h0;
    bus_b.mem_rdata = 64'hCAFEF00D_12345678;
    cyc(2);

    // Reset state: ready gated even with both requests pending
    chk("rst_if_ready", bus_a.if_req_ready, 0);
    chk("rst_dm_ready", bus_a.dm_req_ready, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_mem_en", bus_a.mem_en, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_if_rsp", bus_a.if_rsp_valid, 0);
    chk("rst_dm_rsp", bus_a.dm_rsp_valid, 0);
    chk("rst_b_busy", bus_b.busy, 0);
    bus_a.if_req_valid = 1'b0; bus_a.dm_req_valid = 1'b0;
    reset = 1'b0;
    cyc(1);

    // Lone fetches: addr[2]=0 selects low word, addr[2]=1 high word
    do_fetch(64'h8, 32'h00A00093);
    do_fetch(64'hC, 32'hDEADBEEF);

    // Store then load
    do_dm(1'b1, 64'h100, 64'h1234, 64'h0);
    do_dm(1'b0, 64'h100, 64'h0, 64'h1234);

    // Simultaneous requests: data first, fetch accepted at T+5
    bus_a.dm_req_valid = 1'b1; bus_a.dm_req_we = 1'b0; bus_a.dm_req_addr = 64'h100;
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = 64'hC; #1;
    chk("sim_dm_ready", bus_a.dm_req_ready, 1);
    chk("sim_if_ready", bus_a.if_req_ready, 0);
    cyc(1); bus_a.dm_req_valid = 1'b0;
    chk("sim_if_wait_issue", bus_a.if_req_ready, 0);
    cyc(3);
    chk("sim_if_wait_resp", bus_a.if_req_ready, 0);
    chk("sim_dm_rsp", bus_a.dm_rsp_data, 64'h1234);
    cyc(1);
    chk("sim_if_ready_t5", bus_a.if_req_ready, 1);
    cyc(1); bus_a.if_req_valid = 1'b0;
    chk("sim_if_mem_addr", bus_a.mem_addr, 64'hC);
    cyc(3);
    chk("sim_if_rsp", bus_a.if_rsp_valid, 1);
    chk("sim_if_data", bus_a.if_rsp_data, 32'hDEADBEEF);
    cyc(1);

    // Back-to-back data with fetch held valid
    bus_a.dm_req_valid = 1'b1; bus_a.dm_req_addr = 64'h100;
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = 64'h8;
    for (int k = 0; k < 5; k++) begin
      logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (k == 4);
`else
      exp_if = 1'b0;
`endif
      #1;
      chk("starve_dm_ready", bus_a.dm_req_ready, !exp_if);
      chk("starve_if_ready", bus_a.if_req_ready, exp_if);
      cyc(5);
    end
    bus_a.dm_req_valid = 1'b0; bus_a.if_req_valid = 1'b0;
    cyc(1);

    // Reset during WAIT abandons the load; next request accepted at once
    bus_a.dm_req_valid = 1'b1; bus_a.dm_req_addr = 64'h100; #1;
    chk("rw_dm_ready", bus_a.dm_req_ready, 1);
    cyc(1); bus_a.dm_req_valid = 1'b0;
    cyc(1);
    chk("rw_busy_wait", bus_a.busy, 1);
    reset = 1'b1;
    cyc(1);
    chk("rw_busy_after", bus_a.busy, 0);
    chk("rw_no_rsp", bus_a.dm_rsp_valid, 0);
    reset = 1'b0;
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = 64'hC; #1;
    chk("rw_if_ready", bus_a.if_req_ready, 1);
    cyc(1); bus_a.if_req_valid = 1'b0;
    chk("rw_issue", bus_a.mem_en, 1);
    chk("rw_no_rsp_slot", bus_a.dm_rsp_valid, 0);
    cyc(2);
    chk("rw_if_rsp_early", bus_a.if_rsp_valid, 0);
    cyc(1);
    chk("rw_if_rsp", bus_a.if_rsp_valid, 1);
    chk("rw_if_data", bus_a.if_rsp_data, 32'hDEADBEEF);
    chk("rw_dm_rsp", bus_a.dm_rsp_valid, 0);
    cyc(1);

    // MEM_LAT=1: response 3 cycles after accept, busy for 3 cycles
    bus_b.if_req_valid = 1'b1; bus_b.if_req_addr = 64'h4; #1;
    chk("l1_if_ready", bus_b.if_req_ready, 1);
    chk("l1_busy_t0", bus_b.busy, 0);
    cyc(1); bus_b.if_req_valid = 1'b0;
    chk("l1_busy_t1", bus_b.busy, 1);
    chk("l1_mem_en", bus_b.mem_en, 1);
    cyc(1);
    chk("l1_busy_t2", bus_b.busy, 1);
    chk("l1_rsp_t2", bus_b.if_rsp_valid, 0);
    cyc(1);
    chk("l1_busy_t3", bus_b.busy, 1);
    chk("l1_rsp_t3", bus_b.if_rsp_valid, 1);
    chk("l1_data", bus_b.if_rsp_data, 32'hCAFEF00D);
    cyc(1);
    chk("l1_busy_t4", bus_b.busy, 0);
    chk("l1_rsp_t4", bus_b.if_rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
